// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the Ultiparc instruction fetch stage.
// Holds bus widths, the NOP encoding, the reset PC default and the fetch FSM encoding.
package instr_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_FETCH   = 2'd1,
        IF_HOLD    = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_t;

    // Instructions are word aligned; the low two address bits never reach the bus.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction bus and feeds decode
// one word per cycle, buffering across external stalls and absorbing redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_exec_stall,
    input  logic               i_mem_stall,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic               o_imem_rd,
    input  logic [INSTR_W-1:0] i_imem_data,
    input  logic               i_imem_rdy,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_fetch_stall
);

    localparam logic [ADDR_W-1:0] PC_BASE = word_align(RESET_PC);

    if_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               rd_d;
    logic [INSTR_W-1:0] hold_q, hold_d;

    logic               ext_stall;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_next;

    assign ext_stall = i_exec_stall | i_mem_stall;
    assign target    = word_align(i_redirect_addr);
    assign pc_next   = pc_q + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_IDLE;
            pc_q        <= PC_BASE;
            o_imem_rd   <= 1'b0;
            o_imem_addr <= PC_BASE;
            hold_q      <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            o_imem_rd   <= rd_d;
            o_imem_addr <= addr_d;
            hold_q      <= hold_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rd_d          = o_imem_rd;
        addr_d        = o_imem_addr;
        hold_d        = hold_q;
        o_instr       = NOP;
        o_pc          = pc_q;
        o_fetch_stall = 1'b1;

        case (state_q)
            IF_IDLE: begin
                state_d = IF_FETCH;
                rd_d    = 1'b1;
                if (i_redirect) begin
                    pc_d   = target;
                    addr_d = target;
                end else begin
                    addr_d = pc_q;
                end
            end

            IF_FETCH: begin
                if (i_imem_rdy) begin
                    // The word is presented even when redirecting; the delay slot is decode's concern.
                    o_instr       = i_imem_data;
                    o_fetch_stall = 1'b0;
                    if (i_redirect) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (!ext_stall) begin
                        pc_d   = pc_next;
                        addr_d = pc_next;
                    end else begin
                        hold_d  = i_imem_data;
                        rd_d    = 1'b0;
                        state_d = IF_HOLD;
                    end
                end else if (i_redirect) begin
                    // Bus request must complete untouched; remember the target and drop its data later.
                    pc_d    = target;
                    state_d = IF_DISCARD;
                end
            end

            IF_HOLD: begin
                o_instr       = hold_q;
                o_fetch_stall = 1'b0;
                if (i_redirect) begin
                    pc_d    = target;
                    addr_d  = target;
                    rd_d    = 1'b1;
                    hold_d  = NOP;
                    state_d = IF_FETCH;
                end else if (!ext_stall) begin
                    pc_d    = pc_next;
                    addr_d  = pc_next;
                    rd_d    = 1'b1;
                    state_d = IF_FETCH;
                end
            end

            IF_DISCARD: begin
                if (i_redirect) begin
                    pc_d = target;
                end
                if (i_imem_rdy) begin
                    addr_d  = i_redirect ? target : pc_q;
                    state_d = IF_FETCH;
                end
            end

            default: state_d = IF_IDLE;
        endcase
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the Ultiparc pipeline. It owns the program counter and drives the instruction memory bus. It delivers one instruction word per cycle to the decode stage, which includes coproc0's decoder. It raises a fetch stall whenever no word is available, and it handles control-flow redirects from execute, including redirects that arrive while a bus request is outstanding.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] are ignored.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_exec_stall`  in  1  execute stage stall.
- `i_mem_stall`  in  1  memory stage stall.
- `i_redirect`  in  1  load a new PC (branch/jump/exception/RFE target).
- `i_redirect_addr`  in  32  redirect target; bits [1:0] are forced to 0.
- `o_imem_addr`  out  32  instruction bus address, registered.
- `o_imem_rd`  out  1  instruction bus read request, registered.
- `i_imem_data`  in  32  instruction bus read data, valid when `i_imem_rdy`=1.
- `i_imem_rdy`  in  1  read completes this cycle.
- `o_instr`  out  32  instruction to decode; NOP (32'h0) when not valid.
- `o_pc`  out  32  address of `o_instr`.
- `o_fetch_stall`  out  1  1 = no valid instruction this cycle.

## Operation
- `ext_stall` = `i_exec_stall` | `i_mem_stall`. A delivered word is consumed in a cycle when `o_fetch_stall`=0 and `ext_stall`=0.
- FSM states:
  - IDLE: post-reset only.
  - FETCH: request outstanding.
  - HOLD: word buffered while stalled.
  - DISCARD: stale request in flight.
- Reset values: state=IDLE, pc=`RESET_PC`, `o_imem_rd`=0, `o_imem_addr`=`RESET_PC`, hold buffer=NOP, `o_instr`=NOP, `o_pc`=`RESET_PC`, `o_fetch_stall`=1.
- IDLE → FETCH on the first edge after reset: `o_imem_rd`<=1, `o_imem_addr`<=pc.
- Bus rule: once `o_imem_rd`=1, the request stays asserted with `o_imem_addr` stable until `i_imem_rdy`=1. `o_imem_rd` never deasserts with a request pending.
- FETCH, rdy=1, `ext_stall`=0:
  - `o_instr`=`i_imem_data`, `o_pc`=pc, `o_fetch_stall`=0 (combinational pass-through).
  - pc<=pc+4 and a new request is issued at pc+4; state remains FETCH.
- FETCH, rdy=1, `ext_stall`=1: word goes to the hold buffer, `o_imem_rd`<=0, state → HOLD. `o_fetch_stall` stays 0 (decode does not latch because of the external stall).
- FETCH, rdy=0: `o_fetch_stall`=1, `o_instr`=NOP.
- HOLD: `o_instr`=buffer, `o_fetch_stall`=0. When `ext_stall`=0: pc<=pc+4, request issued, state → FETCH.
- Redirect has the highest priority. In every state, `i_redirect`=1 sets pc<=`i_redirect_addr` & ~3.
  - Same-cycle delivery: if a word is delivered in that cycle, it is still presented and consumed normally. Dropping the delay slot is the control unit's job, not this block's.
  - FETCH with rdy=1, or HOLD: buffer is discarded; the next request uses the new pc; state → FETCH.
  - FETCH with rdy=0: state → DISCARD. On the rdy that completes the stale request, the data is dropped (`o_fetch_stall`=1) and a request to the new pc is issued.
  - DISCARD: a further redirect overwrites pc; the state remains DISCARD.
- pc arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- A mid-operation reset aborts any pending request immediately (`o_imem_rd`=0) and returns the block to its reset values.

## Timing
- Zero-wait memory (rdy in the same cycle as rd): one instruction per cycle. The first instruction appears in the cycle after reset is released.
- N wait states: N+1 cycles per instruction; `o_fetch_stall`=1 during the N wait cycles.
- Redirect penalty, zero-wait memory: a redirect asserted in cycle t puts the target's request on the bus in cycle t+1 and delivers its word in t+1.
- Redirect penalty with a request pending: the remaining latency of the stale request is added, plus one request.
- Resuming from HOLD: the next request is issued on the edge at which `ext_stall` falls.

## Structure
- Add to `cpu_const.vh`:
  - the NOP encoding;
  - FSM state encodings (`CPU_IF_IDLE`, `CPU_IF_FETCH`, `CPU_IF_HOLD`, `CPU_IF_DISCARD`, 2 bits);
  - the `RESET_PC` default.
- Widths come from `cpu_common.vh` (`CPU_ADDR_WIDTH`, `CPU_INSTR_WIDTH`).
- Single module; no sub-module is warranted.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory, no stalls → requests at 0x100, 0x104, 0x108 on consecutive cycles; `o_fetch_stall`=0 from the first delivery onward.
- Memory with 2 wait states → `o_fetch_stall` pattern 1,1,0 repeating; `o_imem_addr` stable while `o_imem_rd`=1.
- Word 0x2400_0001 at 0x104, `ext_stall`=1 for 3 cycles on delivery → state HOLD, `o_instr`=0x2400_0001 throughout, no bus request; fetch at 0x108 on release.
- Redirect to 0x203 during a pending wait-state fetch of 0x10C → stale data dropped with `o_fetch_stall`=1; next request at 0x200; `o_pc`=0x200 on delivery.
- pc=32'hFFFF_FFFC, zero-wait memory → next request at 32'h0000_0000.
- Assert `rst` mid-request → `o_imem_rd`=0 asynchronously; after release, fetch restarts at `RESET_PC`.
